// File: rtl/demux2_pipe.sv
// demux2_pipe: registered 1-to-2 valid/ready stream demultiplexer.
// Each accepted input word is steered by in_sel into one of two
// independent one-entry output registers, so a stalled sink never blocks
// traffic bound for the other sink. A full branch whose sink is ready
// drains and refills in the same cycle, so it sustains one word per cycle.
// Optional feature: define DEMUX2_STATS_EN to add per-branch 16-bit
// wrapping drain counters on ports count0/count1.
module demux2_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX2_STATS_EN
  ,
  output logic [15:0]      count0,
  output logic [15:0]      count1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } br_state_t;

  // Branch state registers (stage p0 is the output register stage).
  br_state_t        st0_p0, st1_p0;
  br_state_t        st0_nxt, st1_nxt;
  logic [WIDTH-1:0] data0_p0, data1_p0;

  // Handshake decode.
  logic room0, room1;
  logic accept;
  logic load0, load1;
  logic drain0, drain1;

  // Branch transition: a load always leaves the branch FULL (covers the
  // simultaneous drain-and-refill case); a drain without load empties it.
  function automatic br_state_t next_state(input br_state_t cur,
                                           input logic      load,
                                           input logic      drain);
    br_state_t nxt;
    nxt = cur;
    if (load) begin
      nxt = FULL;
    end else if (drain) begin
      nxt = EMPTY;
    end
    return nxt;
  endfunction

  // Counter step; 16-bit arithmetic wraps FFFF -> 0000 naturally.
  function automatic logic [15:0] inc_wrap(input logic [15:0] cnt);
    return cnt + 16'd1;
  endfunction

  // Input readiness depends only on the selected branch, never on in_valid.
  always_comb begin
    room0    = (st0_p0 == EMPTY) || out0_ready;
    room1    = (st1_p0 == EMPTY) || out1_ready;
    in_ready = in_sel ? room1 : room0;
    accept   = in_valid && in_ready;
    load0    = accept && !in_sel;
    load1    = accept &&  in_sel;
    drain0   = (st0_p0 == FULL) && out0_ready;
    drain1   = (st1_p0 == FULL) && out1_ready;
  end

  // Next-state logic for both branch FSMs.
  always_comb begin
    st0_nxt = st0_p0;
    st1_nxt = st1_p0;
    st0_nxt = next_state(st0_p0, load0, drain0);
    st1_nxt = next_state(st1_p0, load1, drain1);
  end

  // ---- stage p0: branch state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_p0 <= EMPTY;
      st1_p0 <= EMPTY;
    end else begin
      st0_p0 <= st0_nxt;
      st1_p0 <= st1_nxt;
    end
  end

  // Branch data registers: capture only on a load, otherwise hold so the
  // word stays stable while the sink stalls. Cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_p0 <= '0;
      data1_p0 <= '0;
    end else begin
      if (load0) begin
        data0_p0 <= in_data;
      end
      if (load1) begin
        data1_p0 <= in_data;
      end
    end
  end

  // Output drive straight from the branch registers.
  always_comb begin
    out0_valid = (st0_p0 == FULL);
    out1_valid = (st1_p0 == FULL);
    out0_data  = data0_p0;
    out1_data  = data1_p0;
  end

`ifdef DEMUX2_STATS_EN
  logic [15:0] cnt0_p0, cnt1_p0;

  // Completed-transfer counters, one per branch, stepped on each drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_p0 <= 16'd0;
      cnt1_p0 <= 16'd0;
    end else begin
      if (drain0) begin
        cnt0_p0 <= inc_wrap(cnt0_p0);
      end
      if (drain1) begin
        cnt1_p0 <= inc_wrap(cnt1_p0);
      end
    end
  end

  assign count0 = cnt0_p0;
  assign count1 = cnt1_p0;
`endif

endmodule

// File: tb/tb_demux2_pipe.sv
// Testbench for demux2_pipe: table-driven directed rows, hand-written
// streaming / async-reset / counter-wrap sequences, and a randomized phase
// checked against a queue-based reference model.
module tb_demux2_pipe;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
`ifdef DEMUX2_STATS_EN
  logic [15:0]      count0;
  logic [15:0]      count1;
`endif

  int checks = 0;
  int errors = 0;

  demux2_pipe #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX2_STATS_EN
    ,
    .count0     (count0),
    .count1     (count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // Reset with idle inputs; leaves time at posedge+1 with both branches empty.
  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       vld;
    logic       sel;
    logic [7:0] data;
    logic       r0;
    logic       r1;
    logic       exp_rdy;
    logic       exp_v0;
    logic [7:0] exp_d0;
    logic       exp_v1;
    logic [7:0] exp_d1;
  } vec_t;

  vec_t tbl[15];

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  initial begin
    logic exp_rdy;

    // vld sel data r0 r1 | rdy v0 d0 v1 d1 (outputs after the edge)
    tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 8'h22};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 8'h22};
    tbl[3]  = '{1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h22};
    tbl[4]  = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 8'h22};
    tbl[5]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1, 8'hB0};
    tbl[6]  = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 8'hB0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 8'hB0};
    tbl[8]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 8'hB0};
    tbl[9]  = '{1'b1, 1'b0, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 8'hB0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 8'hB0};
    tbl[11] = '{1'b1, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 1'b1, 8'hC1};
    tbl[12] = '{1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 1'b1, 8'hC1};
    tbl[13] = '{1'b0, 1'b0, 8'hDD, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 1'b1, 8'hC1};
    tbl[14] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 8'hC1};

    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst out0_valid", out0_valid, 0);
    chk("rst out1_valid", out1_valid, 0);
    chk("rst out0_data", out0_data, 0);
    chk("rst out1_data", out1_data, 0);
    chk("rst in_ready sel0", in_ready, 1);
    in_sel = 1'b1;
    #1;
    chk("rst in_ready sel1", in_ready, 1);
`ifdef DEMUX2_STATS_EN
    chk("rst count0", count0, 0);
    chk("rst count1", count1, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].exp_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out0_valid", i), out0_valid, tbl[i].exp_v0);
      chk($sformatf("row%0d out0_data", i), out0_data, tbl[i].exp_d0);
      chk($sformatf("row%0d out1_valid", i), out1_valid, tbl[i].exp_v1);
      chk($sformatf("row%0d out1_data", i), out1_data, tbl[i].exp_d1);
    end

    // Back-to-back stream of 16 words into branch 1.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
      #1;
      chk($sformatf("stream%0d in_ready", i), in_ready, 1);
      if (i > 0) begin
        chk($sformatf("stream%0d out1_valid", i), out1_valid, 1);
        chk($sformatf("stream%0d out1_data", i), out1_data, i - 1);
      end
      @(posedge clk);
      #1;
    end
    chk("stream last valid", out1_valid, 1);
    chk("stream last data", out1_data, 8'h0F);
    chk("stream out0 idle", out0_valid, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("stream drained", out1_valid, 0);

    // Asynchronous reset with both branches full.
    drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre-rst out0_valid", out0_valid, 1);
    chk("pre-rst out1_valid", out1_valid, 1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst out0_valid", out0_valid, 0);
    chk("async rst out1_valid", out1_valid, 0);
    chk("async rst out0_data", out0_data, 0);
    chk("async rst out1_data", out1_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
    #1;
    chk("post-rst in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("post-rst out0_valid", out0_valid, 1);
    chk("post-rst out0_data", out0_data, 8'h77);

    // Randomized traffic against a queue model.
    do_reset();
    q0.delete();
    q1.delete();
    for (int n = 0; n < 500; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 2) != 0));
      #1;
      exp_rdy = in_sel ? (q1.size() == 0 || out1_ready)
                       : (q0.size() == 0 || out0_ready);
      chk("rand in_ready", in_ready, exp_rdy);
      chk("rand out0_valid", out0_valid, q0.size() != 0);
      chk("rand out1_valid", out1_valid, q1.size() != 0);
      if (q0.size() != 0) chk("rand out0_data", out0_data, q0[0]);
      if (q1.size() != 0) chk("rand out1_data", out1_data, q1[0]);
      @(posedge clk);
      if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
      if (in_valid && exp_rdy) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
      #1;
    end

`ifdef DEMUX2_STATS_EN
    // 65537 drains on branch 0 wrap its counter to 1; branch 1 untouched.
    do_reset();
    for (int n = 0; n < 65537; n++) begin
      drive(1'b1, 1'b0, 8'(n), 1'b1, 1'b0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("count0 wrap", count0, 1);
    chk("count1 untouched", count1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux2_pipe.md
# demux2_pipe

Registered 1-to-2 stream demultiplexer: the routing counterpart to `mux2`. It accepts one valid/ready input stream and steers each accepted word to output 0 or output 1 according to a per-word select bit. Each branch has its own one-entry output register, so a stalled sink does not block traffic bound for the other sink. It sits between a single producer (e.g. fetch/decode) and two consumers (e.g. ALU path vs. load/store path) in the CPU datapath.

## Interface
- `WIDTH`, default 8: data width of the input and both outputs.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  producer has a word.
- `in_ready`  output  1  demux accepts the word this cycle.
- `in_data`  input  WIDTH  input word.
- `in_sel`  input  1  destination: 0 → branch 0, 1 → branch 1; sampled with `in_data`.
- `out0_valid` / `out1_valid`  output  1  branch register holds a word.
- `out0_ready` / `out1_ready`  input  1  sink consumes the word this cycle.
- `out0_data` / `out1_data`  output  WIDTH  branch register contents.
- `count0` / `count1`  output  16  completed output transfers per branch (only with `DEMUX2_STATS_EN`).

## Operation
- Each branch N has a state: EMPTY (`outN_valid`=0) or FULL (`outN_valid`=1).
- Input handshake: accept = `in_valid && in_ready`.
- `in_ready` = EMPTY(sel) || `outN_ready` of the selected branch N = `in_sel`; combinational from `in_sel`, branch state and `outN_ready`, never from `in_valid`.
- Output handshake on branch N: drain = `outN_valid && outN_ready`.
- Branch N next state:
  - EMPTY, accept to N → FULL, data = `in_data`.
  - FULL, drain, no accept to N → EMPTY.
  - FULL, drain and accept to N in the same cycle → FULL, data replaced by the new word with no bubble.
  - FULL, no drain → FULL, data held.
- Accepted words are never dropped or duplicated.
- Order is preserved within a branch. Order across branches is not guaranteed.
- The non-selected branch keeps draining independently while the input targets the other branch.
- `outN_data` is stable while `outN_valid && !outN_ready`.
- `in_data` and `in_sel` are ignored when `in_valid`=0.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0): `out0_valid`=`out1_valid`=0, `out0_data`=`out1_data`=0, `count0`=`count1`=0.
- After reset, both branches are EMPTY, so `in_ready`=1 for either `in_sel`.
- Latency: a word accepted at edge k appears on `outN_valid`/`outN_data` after edge k, one cycle.
- Throughput: one word per cycle into a branch whose sink holds `outN_ready`=1 continuously.
- Full branch with `outN_ready`=0: `in_ready`=0 while `in_sel` selects it; `in_ready` is unaffected when `in_sel` selects the other branch.
- Reset asserted mid-operation: held words are discarded, valids drop asynchronously, and counters clear. The first accept can occur on the first rising edge after `rst_n` deasserts.

## Configuration
- Macro: `DEMUX2_STATS_EN`.
- When defined: ports `count0` and `count1` exist. Each 16-bit counter increments by 1 on every drain of its branch, wraps 16'hFFFF → 16'h0000, and clears on reset.
- When undefined: the counters and ports are absent, and the datapath behaviour is identical.

## Test plan
- Reset, then drive 0x11 on sel 0 and 0x22 on sel 1 on consecutive cycles with both readys = 1 → `out0_data`=0x11 the cycle after the first accept, `out1_data`=0x22 one cycle later, each valid for exactly one cycle.
- Hold `out0_ready`=0, send 0xA0 then 0xA1 to branch 0 → 0xA0 is held stable and `in_ready`=0 on the second word. Switch `in_sel`=1 and send 0xB0 → it is accepted and appears on branch 1. Release `out0_ready` → 0xA0 is drained and 0xA1 is accepted the same cycle.
- Stream 0x00..0x0F to branch 1 with `out1_ready`=1 continuously → 16 back-to-back outputs in order, `in_ready` never drops.
- With branch 0 FULL (0x55) and `out0_ready`=1 while 0x66 is offered to branch 0 → simultaneous drain and fill, and `out0_data`=0x66 the next cycle with `out0_valid` staying 1.
- Assert `rst_n`=0 with both branches FULL → both valids drop immediately, data=0. After release, the first new word passes normally.
- With `DEMUX2_STATS_EN`: 65 537 drains on branch 0 → `count0`=1 after wrap, and `count1` unchanged.
